ser_des_link_ctrl: RTL and testbench
====================================

Name: ser_des_link_ctrl

Overview:
- Sequences one burst transfer across the connect_ser_des loopback datapath.
- Fetches up to 16 bytes from a 16x8 pattern buffer and hands them one at a time to the serializer.
- Collects the bytes returned by the deserializer and compares each against the byte sent.
- Reports completion, error count, first failing index and timeout; sits between the test/pattern memory and the serdes pair.

Parameters:
- DEPTH_LOG2, 4, log2 of the pattern buffer depth (16 entries).
- TIMEOUT, 64, max clk cycles without a deserializer byte while bytes are outstanding.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- num_bytes  in  5  burst length 0..16, sampled on accepted start.
- rd_addr  out  4  pattern buffer address.
- rd_data  in  8  pattern buffer data; synchronous read, valid 1 cycle after rd_addr.
- ser_ready  in  1  serializer can accept a byte.
- ser_load  out  1  byte handoff strobe; transfer occurs when ser_load && ser_ready.
- ser_data  out  8  byte to serializer (in_comp side).
- des_valid  in  1  one-cycle strobe, deserializer byte available.
- des_data  in  8  received byte (out_comp side).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err_cnt  out  5  number of mismatching bytes in the last burst.
- first_err_idx  out  4  index of the first mismatch; valid when err_cnt != 0.
- timeout  out  1  last burst ended by timeout.

Behaviour:
- Reset (async, nreset=0): all outputs 0; state IDLE; tx_idx = rx_idx = 0; shadow register file contents don't-care.
- TX FSM states: IDLE, FETCH, LOAD, DRAIN.
  - IDLE: on start with num_bytes=0 → pulse done next cycle, busy stays 0, results cleared. On start with num_bytes>0 → latch N, clear err_cnt, first_err_idx and timeout, set busy, rd_addr=0, go to FETCH.
  - FETCH: one wait cycle for rd_data.
  - LOAD: ser_data = rd_data, hold ser_load=1 until ser_ready. On transfer: write shadow[tx_idx] = ser_data, increment tx_idx. If tx_idx+1 == N go to DRAIN; else rd_addr = tx_idx+1 and go to FETCH.
  - Throughput is at most one byte per 2 cycles. ser_data must be stable while ser_load is high.
  - DRAIN: wait until rx_idx == N or timeout, then pulse done, drop busy, return to IDLE.
- RX path runs concurrently whenever busy:
  - On des_valid: compare des_data with shadow[rx_idx].
  - On mismatch: err_cnt+1, saturating at 16. If this is the first mismatch, first_err_idx = rx_idx.
  - rx_idx increments on every des_valid.
- Out-of-range receive: des_valid with rx_idx >= tx_idx counts as a mismatch. This covers bytes received before any send and bytes beyond N. The shadow entry is not read in that case.
- des_valid while not busy is ignored.
- Same-cycle shadow write and read of the same index: the incoming ser_data is compared (write-through bypass).
- Timeout counter:
  - Counts cycles while busy and rx_idx < tx_idx with no des_valid; clears on des_valid or whenever rx_idx == tx_idx.
  - Reaching TIMEOUT: set timeout=1, add (N - rx_idx) to err_cnt (saturating), pulse done, return to IDLE.
  - Applies in LOAD and DRAIN alike.
- start while busy is ignored.
- Reset asserted mid-burst aborts immediately to the reset state; no done pulse.
- err_cnt, first_err_idx and timeout hold until the next accepted start.

Test Plan:
- Loopback clean: buffer 0x00..0x0F, num_bytes=16, des returns the same bytes 3 cycles after each load → done once, err_cnt=0, timeout=0, exactly 16 ser_load transfers.
- Corruption: num_bytes=8, byte 3 returned as 0xA5 instead of 0x03 and byte 6 flipped → err_cnt=2, first_err_idx=3.
- Backpressure: ser_ready low for 10 cycles during byte 2 → ser_load stays high with ser_data=0x02 held stable; result err_cnt=0.
- Timeout: num_bytes=4, deserializer returns only 2 bytes → timeout=1 after 64 idle cycles, err_cnt=2, done pulses once.
- Zero/ignore: start with num_bytes=0 → done 1 cycle later, busy never high. Start pulsed mid-burst → no effect. Spurious des_valid while idle → err_cnt unchanged.
- Reset mid-burst: nreset low at byte 5 → all outputs 0 immediately. A new start after release with num_bytes=2 completes cleanly.

Source files
------------

// File: rtl/ser_des_link_ctrl.sv
// Burst sequencer for the serdes loopback: streams pattern-buffer bytes into the
// serializer and scores each byte returned by the deserializer against a shadow copy.
module ser_des_link_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 64,
  parameter int TO_W       = 7
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [DEPTH_LOG2:0]   num_bytes,
  output logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  input  logic                  ser_ready,
  output logic                  ser_load,
  output logic [7:0]            ser_data,
  input  logic                  des_valid,
  input  logic [7:0]            des_data,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   err_cnt,
  output logic [DEPTH_LOG2-1:0] first_err_idx,
  output logic                  timeout
);

  localparam int IW = DEPTH_LOG2 + 1;
  localparam logic [IW-1:0] DEPTH = IW'(1 << DEPTH_LOG2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [IW-1:0] sat_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, DEPTH}) begin
      return DEPTH;
    end else begin
      return sum[IW-1:0];
    end
  endfunction

  state_t                state_r, state_n;
  logic [IW-1:0]         len_r, len_n;
  logic [IW-1:0]         tx_idx_r, tx_idx_n;
  logic [IW-1:0]         rx_idx_r, rx_idx_n;
  logic [TO_W-1:0]       to_cnt_r, to_cnt_n;
  logic [DEPTH_LOG2-1:0] rd_addr_r, rd_addr_n;
  logic                  ser_load_r;
  logic                  busy_r, busy_n;
  logic                  done_r, done_n;
  logic [IW-1:0]         err_cnt_r, err_n;
  logic [DEPTH_LOG2-1:0] first_err_r, first_n;
  logic                  timeout_r, timeout_n;
  logic [7:0]            shadow_r [1 << DEPTH_LOG2];

  logic       xfer_s;
  logic       rx_hit_s;
  logic       in_range_s;
  logic [7:0] exp_byte_s;
  logic       mismatch_s;
  logic       counting_s;
  logic       to_fire_s;

  // ser_data follows the buffer output, which stays put while rd_addr holds in LOAD
  assign ser_data = ser_load_r ? rd_data : 8'h00;
  assign xfer_s   = ser_load_r && ser_ready;
  assign rx_hit_s = busy_r && des_valid;

  // Expected receive byte: bypass the shadow when it is being written this cycle
  always_comb begin
    in_range_s = 1'b0;
    exp_byte_s = 8'h00;
    if (xfer_s && (rx_idx_r == tx_idx_r)) begin
      in_range_s = 1'b1;
      exp_byte_s = ser_data;
    end else if (rx_idx_r < tx_idx_r) begin
      in_range_s = 1'b1;
      exp_byte_s = shadow_r[rx_idx_r[DEPTH_LOG2-1:0]];
    end else begin
      in_range_s = 1'b0;
      exp_byte_s = 8'h00;
    end
  end

  assign mismatch_s = rx_hit_s && (!in_range_s || (des_data != exp_byte_s));
  assign counting_s = busy_r && !des_valid && (rx_idx_r < tx_idx_r);
  assign to_fire_s  = counting_s && (to_cnt_r == TO_W'(TIMEOUT - 1));

  // Next-state and result update for the TX sequencer and RX scoreboard
  always_comb begin
    state_n   = state_r;
    len_n     = len_r;
    tx_idx_n  = tx_idx_r;
    rx_idx_n  = rx_idx_r;
    to_cnt_n  = to_cnt_r;
    rd_addr_n = rd_addr_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    err_n     = err_cnt_r;
    first_n   = first_err_r;
    timeout_n = timeout_r;

    if (rx_hit_s) begin
      rx_idx_n = (rx_idx_r == {IW{1'b1}}) ? rx_idx_r : rx_idx_r + IW'(1);
      to_cnt_n = {TO_W{1'b0}};
      if (mismatch_s) begin
        err_n   = sat_add(err_cnt_r, IW'(1));
        first_n = (err_cnt_r == {IW{1'b0}}) ? rx_idx_r[DEPTH_LOG2-1:0] : first_err_r;
      end else begin
        err_n   = err_cnt_r;
      end
    end else if (counting_s) begin
      to_cnt_n = to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_n = {TO_W{1'b0}};
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          err_n     = {IW{1'b0}};
          first_n   = {DEPTH_LOG2{1'b0}};
          timeout_n = 1'b0;
          if (num_bytes == {IW{1'b0}}) begin
            done_n = 1'b1;
          end else begin
            len_n     = (num_bytes > DEPTH) ? DEPTH : num_bytes;
            busy_n    = 1'b1;
            rd_addr_n = {DEPTH_LOG2{1'b0}};
            tx_idx_n  = {IW{1'b0}};
            rx_idx_n  = {IW{1'b0}};
            to_cnt_n  = {TO_W{1'b0}};
            state_n   = FETCH;
          end
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        if (xfer_s) begin
          tx_idx_n = tx_idx_r + IW'(1);
          if (tx_idx_n == len_r) begin
            state_n = DRAIN;
          end else begin
            rd_addr_n = tx_idx_n[DEPTH_LOG2-1:0];
            state_n   = FETCH;
          end
        end else begin
          state_n = LOAD;
        end
      end
      DRAIN: begin
        if (rx_idx_r >= len_r) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outstanding bytes are charged as errors when the deserializer goes quiet
    if (to_fire_s) begin
      timeout_n = 1'b1;
      err_n     = sat_add(err_cnt_r, len_r - rx_idx_r);
      first_n   = (err_cnt_r == {IW{1'b0}}) ? rx_idx_r[DEPTH_LOG2-1:0] : first_err_r;
      done_n    = 1'b1;
      busy_n    = 1'b0;
      to_cnt_n  = {TO_W{1'b0}};
      state_n   = IDLE;
    end else begin
      timeout_n = timeout_n;
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= IDLE;
      len_r       <= {IW{1'b0}};
      tx_idx_r    <= {IW{1'b0}};
      rx_idx_r    <= {IW{1'b0}};
      to_cnt_r    <= {TO_W{1'b0}};
      rd_addr_r   <= {DEPTH_LOG2{1'b0}};
      ser_load_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_cnt_r   <= {IW{1'b0}};
      first_err_r <= {DEPTH_LOG2{1'b0}};
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      len_r       <= len_n;
      tx_idx_r    <= tx_idx_n;
      rx_idx_r    <= rx_idx_n;
      to_cnt_r    <= to_cnt_n;
      rd_addr_r   <= rd_addr_n;
      ser_load_r  <= (state_n == LOAD);
      busy_r      <= busy_n;
      done_r      <= done_n;
      err_cnt_r   <= err_n;
      first_err_r <= first_n;
      timeout_r   <= timeout_n;
    end
  end

  // Shadow copy of every byte handed to the serializer
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      shadow_r[tx_idx_r[DEPTH_LOG2-1:0]] <= ser_data;
    end
  end

  assign rd_addr       = rd_addr_r;
  assign ser_load      = ser_load_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_cnt       = err_cnt_r;
  assign first_err_idx = first_err_r;
  assign timeout       = timeout_r;

endmodule

// File: tb/tb_ser_des_link_ctrl.sv
// Bench for ser_des_link_ctrl: pattern buffer, serializer and loopback deserializer
// models, a vector table, hand sequences, and random bursts scored by a reference model.
module tb_ser_des_link_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic       start;
  logic [4:0] num_bytes;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       ser_ready;
  logic       ser_load;
  logic [7:0] ser_data;
  logic       des_valid;
  logic [7:0] des_data;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic [3:0] first_err_idx;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] pat [16];

  typedef struct {
    int         n;
    int         ret;
    logic [15:0] cmask;
    int         stall_idx;
    int         stall_len;
    bit         mid_start;
    int         abort_at;
    int         exp_err;
    int         exp_first;
    bit         exp_tmo;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } ret_t;

  vec_t tbl [9];

  ser_des_link_ctrl dut (
    .clk(clk), .nreset(nreset), .start(start), .num_bytes(num_bytes),
    .rd_addr(rd_addr), .rd_data(rd_data), .ser_ready(ser_ready),
    .ser_load(ser_load), .ser_data(ser_data), .des_valid(des_valid),
    .des_data(des_data), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Pattern buffer: synchronous read
  always @(posedge clk) rd_data <= pat[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected result of a burst: mismatching returns plus every byte never returned
  function automatic void model(input int n, input int ret, input logic [15:0] cm,
                                output int e, output int f, output bit t);
    e = 0;
    f = -1;
    for (int i = 0; i < ret; i++) begin
      if (cm[i]) begin
        e++;
        if (f < 0) f = i;
      end
    end
    t = (ret < n);
    if (t) begin
      e += n - ret;
      if (f < 0) f = ret;
    end
    if (e > 16) e = 16;
    if (f < 0) f = 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_addr"},  32'(rd_addr), 32'd0);
    chk({tag, " ser_load"}, 32'(ser_load), 32'd0);
    chk({tag, " ser_data"}, 32'(ser_data), 32'd0);
    chk({tag, " busy"},     32'(busy), 32'd0);
    chk({tag, " done"},     32'(done), 32'd0);
    chk({tag, " err_cnt"},  32'(err_cnt), 32'd0);
    chk({tag, " first"},    32'(first_err_idx), 32'd0);
    chk({tag, " timeout"},  32'(timeout), 32'd0);
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    ret_t       q[$];
    int         sent = 0;
    int         done_cnt = 0;
    int         done_c = -1;
    int         last_des_c = -1;
    int         stall_left = v.stall_len;
    bit         hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [4:0] r_err = 5'd0;
    logic [3:0] r_first = 4'd0;
    logic       r_tmo = 1'b0;
    logic       r_busy = 1'b0;
    start = 1'b1;
    num_bytes = 5'(v.n);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    for (int c = 0; c < 600; c++) begin
      if (v.abort_at >= 0 && sent == v.abort_at && ser_load) begin
        nreset = 1'b0;
        des_valid = 1'b0;
        #1;
        chk_all_zero({tag, " abort"});
        repeat (3) begin
          @(negedge clk);
          chk({tag, " abort_no_done"}, 32'(done), 32'd0);
        end
        nreset = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk);
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
          r_err = err_cnt;
          r_first = first_err_idx;
          r_tmo = timeout;
          r_busy = busy;
        end
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      if (hold) begin
        chk({tag, " hold_load"}, 32'(ser_load), 32'd1);
        chk({tag, " hold_data"}, 32'(ser_data), 32'(hold_data));
      end
      if (sent == v.stall_idx && stall_left > 0) begin
        ser_ready = 1'b0;
        stall_left--;
      end else begin
        ser_ready = 1'b1;
      end
      hold = ser_load && !ser_ready;
      hold_data = ser_data;
      if (ser_load && ser_ready) begin
        if (sent < 16) begin
          chk({tag, " tx_data"}, 32'(ser_data), 32'(pat[sent]));
          if (sent < v.ret)
            q.push_back('{c + 3, pat[sent] ^ (v.cmask[sent] ? 8'hA6 : 8'h00)});
        end
        sent++;
      end
      if (q.size() > 0 && q[0].due <= c) begin
        des_valid = 1'b1;
        des_data = q[0].data;
        void'(q.pop_front());
        last_des_c = c;
      end else begin
        des_valid = 1'b0;
        des_data = 8'($urandom);
      end
      if (v.mid_start && c == 5) begin
        start = 1'b1;
        num_bytes = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    des_valid = 1'b0;
    ser_ready = 1'b1;
    chk({tag, " done_seen"}, 32'(done_c >= 0), 32'd1);
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " transfers"}, 32'(sent), 32'(v.n));
    chk({tag, " busy_at_done"}, 32'(r_busy), 32'd0);
    chk({tag, " err_cnt"}, 32'(r_err), 32'(v.exp_err));
    chk({tag, " timeout"}, 32'(r_tmo), 32'(v.exp_tmo));
    if (v.exp_err != 0) chk({tag, " first_err"}, 32'(r_first), 32'(v.exp_first));
    if (v.exp_tmo && v.ret > 0 && v.stall_len == 0)
      chk({tag, " timeout_latency"}, 32'(done_c - last_des_c), 32'd65);
  endtask

  initial begin
    vec_t v;
    int   e, f;
    bit   t;
    nreset = 1'b0;
    start = 1'b0;
    num_bytes = 5'd0;
    ser_ready = 1'b1;
    des_valid = 1'b0;
    des_data = 8'h00;
    for (int i = 0; i < 16; i++) pat[i] = 8'(i);

    tbl[0] = '{16, 16, 16'h0000, -1,  0, 1'b0, -1,  0, 0, 1'b0};
    tbl[1] = '{ 8,  8, 16'h0048, -1,  0, 1'b0, -1,  2, 3, 1'b0};
    tbl[2] = '{ 4,  4, 16'h0000,  2, 10, 1'b0, -1,  0, 0, 1'b0};
    tbl[3] = '{ 4,  2, 16'h0000, -1,  0, 1'b0, -1,  2, 2, 1'b1};
    tbl[4] = '{ 1,  1, 16'h0000, -1,  0, 1'b0, -1,  0, 0, 1'b0};
    tbl[5] = '{16, 16, 16'hFFFF, -1,  0, 1'b0, -1, 16, 0, 1'b0};
    tbl[6] = '{ 8,  8, 16'h0000, -1,  0, 1'b1, -1,  0, 0, 1'b0};
    tbl[7] = '{16,  0, 16'h0000, -1,  0, 1'b0, -1, 16, 0, 1'b1};
    tbl[8] = '{10,  6, 16'h0002, -1,  0, 1'b0, -1,  5, 1, 1'b1};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_burst(tbl[i], $sformatf("vec%0d", i));

    // Spurious deserializer bytes while idle leave the last results alone
    repeat (3) begin
      des_valid = 1'b1;
      des_data = 8'h5A;
      @(negedge clk);
    end
    des_valid = 1'b0;
    @(negedge clk);
    chk("idle_des err_cnt", 32'(err_cnt), 32'd5);
    chk("idle_des first", 32'(first_err_idx), 32'd1);
    chk("idle_des timeout", 32'(timeout), 32'd1);

    // Zero-length burst: done next cycle, busy never set, results cleared
    start = 1'b1;
    num_bytes = 5'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero done", 32'(done), 32'd1);
    chk("zero busy", 32'(busy), 32'd0);
    chk("zero err_cnt", 32'(err_cnt), 32'd0);
    chk("zero timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("zero done_drop", 32'(done), 32'd0);
    chk("zero busy_after", 32'(busy), 32'd0);

    // Reset in the middle of a burst, then a short clean burst
    run_burst('{8, 8, 16'h0000, -1, 0, 1'b0, 5, 0, 0, 1'b0}, "rst_mid");
    run_burst('{2, 2, 16'h0000, -1, 0, 1'b0, -1, 0, 0, 1'b0}, "post_rst");

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
      v.n = int'($urandom_range(1, 16));
      v.ret = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, v.n - 1)) : v.n;
      v.cmask = 16'($urandom) & 16'($urandom) & 16'($urandom);
      v.stall_idx = int'($urandom_range(0, v.n - 1));
      v.stall_len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
      v.mid_start = 1'b0;
      v.abort_at = -1;
      model(v.n, v.ret, v.cmask, e, f, t);
      v.exp_err = e;
      v.exp_first = f;
      v.exp_tmo = t;
      run_burst(v, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
